// File: rtl/sram_uart_bus_ctrl_if.sv
// CPU-side request/response channel of the SRAM/UART/register bus controller.
// The CPU drives the request fields and holds req until ready pulses.
interface sram_uart_bus_ctrl_if;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  logic          req;
  logic          we;
  logic [DW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [BW-1:0] be;
  logic          uns;
  logic          ready;
  logic [DW-1:0] rdata;
  logic          busy;

  modport master (output req, we, addr, wdata, be, uns, input ready, rdata, busy);
  modport slave  (input req, we, addr, wdata, be, uns, output ready, rdata, busy);
endinterface

// File: rtl/sram_uart_bus_ctrl.sv
// Multi-cycle handshaked controller for base/ext SRAM, UART (on base_ram_data[7:0])
// and the LED/DPY registers, with programmable SRAM wait states and UART strobe width.
module sram_uart_bus_ctrl #(
  parameter int unsigned RAM_WAIT       = 2,
  parameter int unsigned UART_PULSE     = 2,
  parameter int unsigned BANK_BIT       = 22,
  parameter logic [31:0] ADDR_UART_DATA = 32'hBFD003F8,
  parameter logic [31:0] ADDR_UART_STAT = 32'hBFD003FC,
  parameter logic [31:0] ADDR_LED       = 32'hBFD00400,
  parameter logic [31:0] ADDR_DPY       = 32'hBFD00408
) (
  input  logic        clk,
  input  logic        rst_n,
  sram_uart_bus_ctrl_if.slave bus,
  inout  wire  [31:0] base_ram_data,
  output logic [19:0] base_ram_addr,
  output logic [3:0]  base_ram_be_n,
  output logic        base_ram_ce_n,
  output logic        base_ram_oe_n,
  output logic        base_ram_we_n,
  inout  wire  [31:0] ext_ram_data,
  output logic [19:0] ext_ram_addr,
  output logic [3:0]  ext_ram_be_n,
  output logic        ext_ram_ce_n,
  output logic        ext_ram_oe_n,
  output logic        ext_ram_we_n,
  output logic        uart_rdn,
  output logic        uart_wrn,
  input  logic        uart_dataready,
  input  logic        uart_tbre,
  input  logic        uart_tsre,
  output logic [15:0] debug_leds,
  output logic [7:0]  debug_dpys
);
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 20;
  localparam int unsigned BW = 4;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] RAM_CNT  = CW'(RAM_WAIT - 1);
  localparam logic [CW-1:0] UART_CNT = CW'(UART_PULSE - 1);

  typedef enum logic [2:0] {
    IDLE, RAM_RD, RAM_WR, RAM_HOLD, UART_RD, UART_WR, UART_HOLD, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] word_q;
  logic          ext_q;
  logic [DW-1:0] wdata_q;
  logic [BW-1:0] be_q;
  logic          uns_q;
  logic          accept;

  logic          ready_q, ready_d, busy_q, busy_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [15:0]   leds_d;
  logic [7:0]    dpys_d;
  logic [AW-1:0] base_addr_d, ext_addr_d;
  logic [BW-1:0] base_be_n_d, ext_be_n_d;
  logic          base_ce_n_d, base_oe_n_d, base_we_n_d;
  logic          ext_ce_n_d, ext_oe_n_d, ext_we_n_d;
  logic          rdn_d, wrn_d;
  logic          base_drv_q, base_drv_d, ext_drv_q, ext_drv_d;
  logic [DW-1:0] base_dout_q, base_dout_d, ext_dout_q, ext_dout_d;

  // Access fields in effect for the next cycle: live inputs while accepting, latched otherwise
  logic [AW-1:0] cur_word;
  logic          cur_ext;
  logic [DW-1:0] cur_wdata;
  logic [BW-1:0] cur_be;
  logic          ram_st, wr_st, uwr_st;

  function automatic logic [DW-1:0] ext8(input logic [7:0] x, input logic u);
    return {{24{x[7] & ~u}}, x};
  endfunction

  function automatic logic [DW-1:0] ext16(input logic [15:0] x, input logic u);
    return {{16{x[15] & ~u}}, x};
  endfunction

  function automatic logic [DW-1:0] fmt_load(input logic [DW-1:0] d, input logic [BW-1:0] b,
                                             input logic u);
    case (b)
      4'b0001: return ext8(d[7:0], u);
      4'b0010: return ext8(d[15:8], u);
      4'b0100: return ext8(d[23:16], u);
      4'b1000: return ext8(d[31:24], u);
      4'b0011: return ext16(d[15:0], u);
      4'b1100: return ext16(d[31:16], u);
      default: return d;
    endcase
  endfunction

  // Right-aligned store data replicated so the enabled lane(s) carry it
  function automatic logic [DW-1:0] place_store(input logic [DW-1:0] w, input logic [BW-1:0] b);
    case (b)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return {4{w[7:0]}};
      4'b0011, 4'b1100:                   return {2{w[15:0]}};
      default:                            return w;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = '0;
    leds_d  = debug_leds;
    dpys_d  = debug_dpys;
    accept  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req) begin
          accept = 1'b1;
          if (bus.addr == ADDR_UART_DATA) begin
            state_d = bus.we ? UART_WR : UART_RD;
            cnt_d   = UART_CNT;
          end else if (bus.addr == ADDR_UART_STAT) begin
            state_d = DONE;
            if (!bus.we) rdata_d = {30'b0, uart_dataready, uart_tbre & uart_tsre};
          end else if (bus.addr == ADDR_LED) begin
            state_d = DONE;
            if (bus.we) leds_d = bus.wdata[15:0];
            else        rdata_d = {16'b0, debug_leds};
          end else if (bus.addr == ADDR_DPY) begin
            state_d = DONE;
            if (bus.we) dpys_d = bus.wdata[7:0];
            else        rdata_d = {24'b0, debug_dpys};
          end else begin
            state_d = bus.we ? RAM_WR : RAM_RD;
            cnt_d   = RAM_CNT;
          end
        end
      end
      RAM_RD: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          rdata_d = fmt_load(ext_q ? ext_ram_data : base_ram_data, be_q, uns_q);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RAM_WR: begin
        if (cnt_q == '0) state_d = RAM_HOLD;
        else             cnt_d   = cnt_q - CW'(1);
      end
      RAM_HOLD: state_d = DONE;
      UART_RD: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          rdata_d = {24'b0, base_ram_data[7:0]};
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      UART_WR: begin
        if (cnt_q == '0) state_d = UART_HOLD;
        else             cnt_d   = cnt_q - CW'(1);
      end
      UART_HOLD: state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    cur_word  = accept ? bus.addr[21:2] : word_q;
    cur_ext   = accept ? bus.addr[BANK_BIT] : ext_q;
    cur_wdata = accept ? bus.wdata : wdata_q;
    cur_be    = accept ? bus.be : be_q;

    ram_st = state_d inside {RAM_RD, RAM_WR, RAM_HOLD};
    wr_st  = state_d inside {RAM_WR, RAM_HOLD};
    uwr_st = state_d inside {UART_WR, UART_HOLD};

    // Pin values are derived from the next state so every strobe and enable is a flop
    base_ce_n_d = !(ram_st && !cur_ext);
    ext_ce_n_d  = !(ram_st && cur_ext);
    base_oe_n_d = !(state_d == RAM_RD && !cur_ext);
    ext_oe_n_d  = !(state_d == RAM_RD && cur_ext);
    base_we_n_d = !(state_d == RAM_WR && !cur_ext);
    ext_we_n_d  = !(state_d == RAM_WR && cur_ext);
    base_be_n_d = (ram_st && !cur_ext) ? ~cur_be : 4'hF;
    ext_be_n_d  = (ram_st && cur_ext) ? ~cur_be : 4'hF;
    base_addr_d = (ram_st && !cur_ext) ? cur_word : base_ram_addr;
    ext_addr_d  = (ram_st && cur_ext) ? cur_word : ext_ram_addr;
    base_drv_d  = (wr_st && !cur_ext) || uwr_st;
    ext_drv_d   = wr_st && cur_ext;
    base_dout_d = uwr_st ? {24'b0, cur_wdata[7:0]} : place_store(cur_wdata, cur_be);
    ext_dout_d  = place_store(cur_wdata, cur_be);
    rdn_d       = !(state_d == UART_RD);
    wrn_d       = !(state_d == UART_WR);
    ready_d     = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      word_q        <= '0;
      ext_q         <= 1'b0;
      wdata_q       <= '0;
      be_q          <= '0;
      uns_q         <= 1'b0;
      ready_q       <= 1'b0;
      busy_q        <= 1'b0;
      rdata_q       <= '0;
      debug_leds    <= '0;
      debug_dpys    <= '0;
      base_ram_addr <= '0;
      base_ram_be_n <= 4'hF;
      base_ram_ce_n <= 1'b1;
      base_ram_oe_n <= 1'b1;
      base_ram_we_n <= 1'b1;
      ext_ram_addr  <= '0;
      ext_ram_be_n  <= 4'hF;
      ext_ram_ce_n  <= 1'b1;
      ext_ram_oe_n  <= 1'b1;
      ext_ram_we_n  <= 1'b1;
      uart_rdn      <= 1'b1;
      uart_wrn      <= 1'b1;
      base_drv_q    <= 1'b0;
      ext_drv_q     <= 1'b0;
      base_dout_q   <= '0;
      ext_dout_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      if (accept) begin
        word_q  <= bus.addr[21:2];
        ext_q   <= bus.addr[BANK_BIT];
        wdata_q <= bus.wdata;
        be_q    <= bus.be;
        uns_q   <= bus.uns;
      end
      ready_q       <= ready_d;
      busy_q        <= busy_d;
      rdata_q       <= rdata_d;
      debug_leds    <= leds_d;
      debug_dpys    <= dpys_d;
      base_ram_addr <= base_addr_d;
      base_ram_be_n <= base_be_n_d;
      base_ram_ce_n <= base_ce_n_d;
      base_ram_oe_n <= base_oe_n_d;
      base_ram_we_n <= base_we_n_d;
      ext_ram_addr  <= ext_addr_d;
      ext_ram_be_n  <= ext_be_n_d;
      ext_ram_ce_n  <= ext_ce_n_d;
      ext_ram_oe_n  <= ext_oe_n_d;
      ext_ram_we_n  <= ext_we_n_d;
      uart_rdn      <= rdn_d;
      uart_wrn      <= wrn_d;
      base_drv_q    <= base_drv_d;
      ext_drv_q     <= ext_drv_d;
      base_dout_q   <= base_dout_d;
      ext_dout_q    <= ext_dout_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;

  assign base_ram_data = base_drv_q ? base_dout_q : {DW{1'bz}};
  assign ext_ram_data  = ext_drv_q ? ext_dout_q : {DW{1'bz}};
endmodule

// File: tb/tb_sram_uart_bus_ctrl.sv
// Directed bench for sram_uart_bus_ctrl: SRAM/UART models on the board side,
// a vector table of accesses, and hand sequences for back-to-back and reset cases.
module tb_sram_uart_bus_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  wire  [31:0] base_ram_data, ext_ram_data;
  logic [19:0] base_ram_addr, ext_ram_addr;
  logic [3:0]  base_ram_be_n, ext_ram_be_n;
  logic        base_ram_ce_n, base_ram_oe_n, base_ram_we_n;
  logic        ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n;
  logic        uart_rdn, uart_wrn;
  logic        uart_dataready = 1'b1, uart_tbre = 1'b1, uart_tsre = 1'b1;
  logic [15:0] debug_leds;
  logic [7:0]  debug_dpys;
  logic [7:0]  uart_rx = 8'hC3;

  sram_uart_bus_ctrl_if bus ();

  sram_uart_bus_ctrl #(.RAM_WAIT(2), .UART_PULSE(3)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .base_ram_data(base_ram_data), .base_ram_addr(base_ram_addr), .base_ram_be_n(base_ram_be_n),
    .base_ram_ce_n(base_ram_ce_n), .base_ram_oe_n(base_ram_oe_n), .base_ram_we_n(base_ram_we_n),
    .ext_ram_data(ext_ram_data), .ext_ram_addr(ext_ram_addr), .ext_ram_be_n(ext_ram_be_n),
    .ext_ram_ce_n(ext_ram_ce_n), .ext_ram_oe_n(ext_ram_oe_n), .ext_ram_we_n(ext_ram_we_n),
    .uart_rdn(uart_rdn), .uart_wrn(uart_wrn), .uart_dataready(uart_dataready),
    .uart_tbre(uart_tbre), .uart_tsre(uart_tsre), .debug_leds(debug_leds), .debug_dpys(debug_dpys)
  );

  always #5 clk = ~clk;

  // Board models: small SRAMs indexed by the low word-address bits, UART RX byte on base[7:0]
  logic [31:0] base_mem [0:63];
  logic [31:0] ext_mem  [0:63];
  assign base_ram_data = (!base_ram_ce_n && !base_ram_oe_n) ? base_mem[base_ram_addr[5:0]] :
                         (!uart_rdn ? {24'h0, uart_rx} : 32'hzzzzzzzz);
  assign ext_ram_data  = (!ext_ram_ce_n && !ext_ram_oe_n) ? ext_mem[ext_ram_addr[5:0]] : 32'hzzzzzzzz;

  always @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (!base_ram_ce_n && !base_ram_we_n && !base_ram_be_n[l])
        base_mem[base_ram_addr[5:0]][8*l +: 8] <= base_ram_data[8*l +: 8];
      if (!ext_ram_ce_n && !ext_ram_we_n && !ext_ram_be_n[l])
        ext_mem[ext_ram_addr[5:0]][8*l +: 8] <= ext_ram_data[8*l +: 8];
    end
  end

  // Pin monitor, sampled on the falling edge
  int          strobe_cnt, uart_bad;
  logic        base_ce_seen, ext_ce_seen, prev_wrn;
  logic [3:0]  be_seen;
  logic [19:0] we_addr;
  logic [7:0]  hold_data;
  logic [7:0]  uart_exp = 8'h41;

  always @(negedge clk) begin
    if (!base_ram_oe_n || !base_ram_we_n || !ext_ram_oe_n || !ext_ram_we_n || !uart_rdn || !uart_wrn)
      strobe_cnt++;
    if (!base_ram_ce_n) begin base_ce_seen = 1'b1; be_seen = base_ram_be_n; end
    if (!ext_ram_ce_n)  begin ext_ce_seen = 1'b1;  be_seen = ext_ram_be_n;  end
    if (!base_ram_we_n) we_addr = base_ram_addr;
    if (!uart_wrn && base_ram_data[7:0] != uart_exp) uart_bad++;
    if (!prev_wrn && uart_wrn) hold_data = base_ram_data[7:0];
    prev_wrn = uart_wrn;
  end

  int n_cmp = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        uns;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_strobe;
    int          exp_bank;   // 0 none, 1 base, 2 ext
  } vec_t;

  task automatic do_access(input vec_t v, output logic [31:0] rd, output int lat);
    int guard = 0;
    do begin @(negedge clk); guard++; end while (bus.busy && guard < 50);
    bus.req = 1'b1; bus.we = v.we; bus.addr = v.addr; bus.wdata = v.wdata;
    bus.be = v.be; bus.uns = v.uns;
    @(posedge clk); #1;
    strobe_cnt = 0; uart_bad = 0; base_ce_seen = 1'b0; ext_ce_seen = 1'b0;
    be_seen = 4'hF; we_addr = 20'hFFFFF; hold_data = 8'h00;
    lat = 1;
    while (!bus.ready && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.ready) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout: no ready for addr %h", v.addr);
    end
    rd = bus.rdata;
    bus.req = 1'b0;
  endtask

  vec_t        vecs [16];
  logic [31:0] rd;
  int          lat, readies;
  logic        prev_rdy, back2back;

  initial begin
    for (int i = 0; i < 64; i++) begin base_mem[i] = '0; ext_mem[i] = '0; end
    ext_mem[8] = 32'h80FF7F01;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.be = '0; bus.uns = 1'b0;

    vecs[0]  = '{1'b1, 32'h80000010, 32'hDEADBEEF, 4'b1111, 1'b0, 32'h00000000, 4, 2, 1};
    vecs[1]  = '{1'b0, 32'h80000010, 32'h0,        4'b1111, 1'b0, 32'hDEADBEEF, 3, 2, 1};
    vecs[2]  = '{1'b0, 32'h80400020, 32'h0,        4'b1000, 1'b0, 32'hFFFFFF80, 3, 2, 2};
    vecs[3]  = '{1'b0, 32'h80400020, 32'h0,        4'b1000, 1'b1, 32'h00000080, 3, 2, 2};
    vecs[4]  = '{1'b0, 32'h80400020, 32'h0,        4'b0011, 1'b0, 32'h00007F01, 3, 2, 2};
    vecs[5]  = '{1'b0, 32'h80400020, 32'h0,        4'b1100, 1'b0, 32'hFFFF80FF, 3, 2, 2};
    vecs[6]  = '{1'b0, 32'h80400020, 32'h0,        4'b0100, 1'b1, 32'h000000FF, 3, 2, 2};
    vecs[7]  = '{1'b1, 32'h80000010, 32'h000000AB, 4'b0100, 1'b0, 32'h00000000, 4, 2, 1};
    vecs[8]  = '{1'b0, 32'h80000010, 32'h0,        4'b1111, 1'b0, 32'hDEABBEEF, 3, 2, 1};
    vecs[9]  = '{1'b1, 32'hBFD00400, 32'h00001234, 4'b1111, 1'b0, 32'h00000000, 1, 0, 0};
    vecs[10] = '{1'b0, 32'hBFD00400, 32'h0,        4'b1111, 1'b0, 32'h00001234, 1, 0, 0};
    vecs[11] = '{1'b1, 32'hBFD00408, 32'h00005A6B, 4'b1111, 1'b0, 32'h00000000, 1, 0, 0};
    vecs[12] = '{1'b0, 32'hBFD00408, 32'h0,        4'b1111, 1'b0, 32'h0000006B, 1, 0, 0};
    vecs[13] = '{1'b0, 32'hBFD003FC, 32'h0,        4'b1111, 1'b0, 32'h00000003, 1, 0, 0};
    vecs[14] = '{1'b0, 32'hBFD003F8, 32'h0,        4'b1111, 1'b0, 32'h000000C3, 4, 3, 0};
    vecs[15] = '{1'b1, 32'hBFD003F8, 32'h00000141, 4'b1111, 1'b0, 32'h00000000, 5, 3, 0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready_busy", {30'b0, bus.ready, bus.busy}, 32'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_strobes", {24'b0, base_ram_ce_n, base_ram_oe_n, base_ram_we_n, ext_ram_ce_n,
                          ext_ram_oe_n, ext_ram_we_n, uart_rdn, uart_wrn}, 32'h000000FF);
    check("rst_be_n", {24'b0, base_ram_be_n, ext_ram_be_n}, 32'h000000FF);
    check("rst_regs", {8'b0, debug_leds, debug_dpys}, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      do_access(vecs[i], rd, lat);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_strobe_cycles", i), 32'(strobe_cnt), 32'(vecs[i].exp_strobe));
      check($sformatf("v%0d_bank", i), {30'b0, ext_ce_seen, base_ce_seen},
            32'(vecs[i].exp_bank));
      check($sformatf("v%0d_be_n", i), {28'b0, be_seen},
            {28'b0, (vecs[i].exp_bank != 0) ? ~vecs[i].be : 4'hF});
      if (i == 0)  check("v0_word_addr", {12'b0, we_addr}, 32'h00004);
      if (i == 9)  check("v9_leds", {16'b0, debug_leds}, 32'h1234);
      if (i == 11) check("v11_dpys", {24'b0, debug_dpys}, 32'h6B);
      if (i == 15) begin
        check("v15_uart_data_low", 32'(uart_bad), 32'h0);
        check("v15_uart_hold_data", {24'b0, hold_data}, 32'h41);
      end
    end

    // Status bit combinations
    uart_dataready = 1'b0; uart_tbre = 1'b1; uart_tsre = 1'b0;
    do_access('{1'b0, 32'hBFD003FC, 32'h0, 4'hF, 1'b0, 32'h0, 1, 0, 0}, rd, lat);
    check("stat_none", rd, 32'h0);
    uart_dataready = 1'b1; uart_tbre = 1'b0; uart_tsre = 1'b1;
    do_access('{1'b0, 32'hBFD003FC, 32'h0, 4'hF, 1'b0, 32'h0, 1, 0, 0}, rd, lat);
    check("stat_rx_only", rd, 32'h2);

    // req held high: one ready per access, one idle cycle in between
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'hBFD00400; bus.be = 4'hF;
    readies = 0; prev_rdy = 1'b0; back2back = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (bus.ready) begin
        readies++;
        if (prev_rdy) back2back = 1'b1;
        if (readies == 1) check("held_rdata", bus.rdata, 32'h00001234);
      end
      prev_rdy = bus.ready;
    end
    bus.req = 1'b0;
    check("held_ready_count", 32'(readies), 32'd4);
    check("held_no_consecutive", {31'b0, back2back}, 32'h0);

    // Asynchronous reset in the middle of a RAM write strobe
    do begin @(negedge clk); end while (bus.busy);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h80000020; bus.wdata = 32'h11111111; bus.be = 4'hF;
    @(posedge clk); #1;
    check("rstmid_we_low", {31'b0, base_ram_we_n}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_strobes", {30'b0, base_ram_we_n, base_ram_ce_n}, 32'h3);
    check("rstmid_leds", {16'b0, debug_leds}, 32'h0);
    bus.req = 1'b0;
    readies = 0;
    repeat (3) begin @(posedge clk); #1; if (bus.ready) readies++; end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; if (bus.ready) readies++; end
    check("rstmid_no_ready", 32'(readies), 32'd0);
    check("rstmid_no_write", base_mem[8], 32'h0);

    do_access('{1'b0, 32'h80000010, 32'h0, 4'hF, 1'b0, 32'h0, 3, 2, 1}, rd, lat);
    check("post_rst_rdata", rd, 32'hDEABBEEF);
    check("post_rst_latency", 32'(lat), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
